// File: rtl/fft_twiddle_sequencer_if.sv
// Butterfly-issue bundle between FFT control, the sequencer and the datapath.
// master: sequencer side (drives busy/done and butterfly fields); slave: environment side.
interface fft_twiddle_sequencer_if #(
  parameter int LOG2N = 4
);
  logic             start;
  logic             busy;
  logic             done;
  logic             bfly_valid;
  logic             bfly_ready;
  logic [LOG2N-1:0] addr_a;
  logic [LOG2N-1:0] addr_b;
  logic [LOG2N-2:0] tw_idx;
  logic [3:0]       stage;

  modport master (
    input  start,
    input  bfly_ready,
    output busy,
    output done,
    output bfly_valid,
    output addr_a,
    output addr_b,
    output tw_idx,
    output stage
  );

  modport slave (
    output start,
    output bfly_ready,
    input  busy,
    input  done,
    input  bfly_valid,
    input  addr_a,
    input  addr_b,
    input  tw_idx,
    input  stage
  );
endinterface

// File: rtl/fft_twiddle_sequencer.sv
// Issues the butterflies of one in-place radix-2 DIT FFT, stage by stage.
// Ports: clk, rst_n (async, active low), bus (master: start/busy/done, bfly handshake, addr/tw/stage).
module fft_twiddle_sequencer #(
  parameter int LOG2N    = 4,
  parameter int PIPE_LAT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fft_twiddle_sequencer_if.master bus
);

  localparam int BW    = LOG2N - 1;
  localparam int CW    = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);
  localparam int LASTC = (PIPE_LAT < 1) ? 0 : PIPE_LAT - 1;

  localparam logic [BW-1:0] B_LAST = '1;
  localparam logic [3:0]    S_LAST = 4'(LOG2N - 1);
  localparam logic [CW-1:0] C_LAST = CW'(LASTC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [3:0]    r_s;
  logic [3:0]    w_s_nxt;
  logic [BW-1:0] r_b;
  logic [BW-1:0] w_b_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  logic             r_busy;
  logic             r_done;
  logic             r_valid;
  logic [LOG2N-1:0] r_addr_a;
  logic [LOG2N-1:0] r_addr_b;
  logic [BW-1:0]    r_tw;

  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_valid_nxt;
  logic [LOG2N-1:0] w_addr_a_nxt;
  logic [LOG2N-1:0] w_addr_b_nxt;
  logic [BW-1:0]    w_tw_nxt;

  logic w_xfer;
  assign w_xfer = r_valid & bus.bfly_ready;

  // Butterfly fields for the (s,b) pair that will be presented next cycle.
  logic [LOG2N-1:0] w_bx;
  logic [LOG2N-1:0] w_h;
  logic [LOG2N-1:0] w_p;
  logic [LOG2N-1:0] w_g;
  logic [LOG2N-1:0] w_fa;
  logic [LOG2N-1:0] w_fb;
  logic [LOG2N-1:0] w_ftw;
  logic [3:0]       w_twsh;

  assign w_bx   = LOG2N'(w_b_nxt);
  assign w_h    = LOG2N'(1) << w_s_nxt;
  assign w_p    = w_bx & (w_h - LOG2N'(1));
  assign w_g    = w_bx >> w_s_nxt;
  assign w_fa   = (w_g << (w_s_nxt + 4'd1)) | w_p;
  assign w_fb   = w_fa + w_h;
  assign w_twsh = S_LAST - w_s_nxt;
  // p < h, so p << (LOG2N-1-s) always fits in the LOG2N-1 bit index.
  assign w_ftw  = w_p << w_twsh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_s      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_tw     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_s      <= w_s_nxt;
      r_b      <= w_b_nxt;
      r_cnt    <= w_cnt_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_valid  <= w_valid_nxt;
      r_addr_a <= w_addr_a_nxt;
      r_addr_b <= w_addr_b_nxt;
      r_tw     <= w_tw_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_b_nxt     = r_b;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = ISSUE;
          w_s_nxt     = '0;
          w_b_nxt     = '0;
        end
      end
      ISSUE: begin
        if (w_xfer) begin
          if (r_b == B_LAST) begin
            w_state_nxt = DRAIN;
            w_cnt_nxt   = '0;
          end else begin
            w_b_nxt = r_b + BW'(1);
          end
        end
      end
      DRAIN: begin
        // With PIPE_LAT=0 the single DRAIN cycle is only the decision point.
        if (r_cnt == C_LAST) begin
          if (r_s == S_LAST) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = ISSUE;
            w_s_nxt     = r_s + 4'd1;
            w_b_nxt     = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    w_busy_nxt   = (w_state_nxt == ISSUE) || (w_state_nxt == DRAIN);
    w_done_nxt   = (w_state_nxt == DONE);
    w_valid_nxt  = (w_state_nxt == ISSUE);
    w_addr_a_nxt = r_addr_a;
    w_addr_b_nxt = r_addr_b;
    w_tw_nxt     = r_tw;
    if (w_state_nxt == ISSUE) begin
      w_addr_a_nxt = w_fa;
      w_addr_b_nxt = w_fb;
      w_tw_nxt     = w_ftw[BW-1:0];
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.bfly_valid = r_valid;
  assign bus.addr_a     = r_addr_a;
  assign bus.addr_b     = r_addr_b;
  assign bus.tw_idx     = r_tw;
  assign bus.stage      = r_s;

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Directed bench for fft_twiddle_sequencer (16-point/PIPE_LAT=3 and 4-point/PIPE_LAT=0).
// Cycle k is the period whose closing edge is k clock edges after the start edge.
module tb_fft_twiddle_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_twiddle_sequencer_if #(.LOG2N(4)) bus ();
  fft_twiddle_sequencer_if #(.LOG2N(2)) bus2 ();

  fft_twiddle_sequencer #(.LOG2N(4), .PIPE_LAT(3)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  fft_twiddle_sequencer #(.LOG2N(2), .PIPE_LAT(0)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int ea [32];
  int eb [32];
  int et [32];
  int es [32];

  int oa [64];
  int ob [64];
  int ot [64];
  int os [64];
  int oc [64];
  int ntr;
  int done_cyc;
  int nstall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready high; 1: 5-cycle stall at s1 b2; 2: random ready.
  task automatic run(input int mode, input int poke);
    int cyc;
    int stall_left;
    logic r;
    bus.start = 1'b1;
    tick();
    bus.start  = 1'b0;
    cyc        = 1;
    ntr        = 0;
    done_cyc   = -1;
    nstall     = 0;
    stall_left = 5;
    while (cyc < 300 && done_cyc < 0) begin
      r = 1'b1;
      if (mode == 1 && bus.bfly_valid && ntr == 10 && stall_left > 0) begin
        r = 1'b0;
        stall_left--;
        chk("stall_a", 32'(bus.addr_a), 4);
        chk("stall_b", 32'(bus.addr_b), 6);
        chk("stall_tw", 32'(bus.tw_idx), 0);
      end
      if (mode == 2) r = 1'($urandom_range(0, 1));
      bus.bfly_ready = r;
      bus.start = (cyc == poke);
      if (bus.bfly_valid && !r) nstall++;
      if (bus.bfly_valid && r && ntr < 64) begin
        oa[ntr] = int'(bus.addr_a);
        ob[ntr] = int'(bus.addr_b);
        ot[ntr] = int'(bus.tw_idx);
        os[ntr] = int'(bus.stage);
        oc[ntr] = cyc;
        ntr++;
      end
      if (bus.done) begin
        done_cyc = cyc;
      end else begin
        tick();
        cyc++;
      end
    end
    bus.start = 1'b0;
    bus.bfly_ready = 1'b1;
    if (done_cyc < 0) chk("run_timeout", 0, 1);
  endtask

  task automatic check_seq(input string tag, input bit exact_gap);
    chk({tag, "_count"}, ntr, 32);
    for (int i = 0; i < 32 && i < ntr; i++) begin
      chk($sformatf("%s_bf%0d", tag, i),
          {oa[i][7:0], ob[i][7:0], ot[i][7:0], os[i][7:0]},
          {ea[i][7:0], eb[i][7:0], et[i][7:0], es[i][7:0]});
    end
    if (ntr >= 32) begin
      for (int s = 1; s < 4; s++) begin
        if (exact_gap)
          chk($sformatf("%s_gap%0d", tag, s), oc[8*s] - oc[8*s-1], 4);
        else
          chk($sformatf("%s_gap%0d", tag, s), 32'(oc[8*s] - oc[8*s-1] >= 4), 1);
      end
    end
  endtask

  initial begin
    int idx;
    int cyc2;
    int n2;
    int d2;
    int a2 [8];
    int b2 [8];
    int t2 [8];

    // Reference ordering: classic DIT loops (stage / group / leg).
    idx = 0;
    for (int s = 0; s < 4; s++) begin
      for (int st = 0; st < 16; st += (2 << s)) begin
        for (int j = 0; j < (1 << s); j++) begin
          ea[idx] = st + j;
          eb[idx] = st + j + (1 << s);
          et[idx] = j * (16 / (2 << s));
          es[idx] = s;
          idx++;
        end
      end
    end

    bus.start       = 1'b0;
    bus.bfly_ready  = 1'b1;
    bus2.start      = 1'b0;
    bus2.bfly_ready = 1'b1;

    // 1: reset values
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_valid", 32'(bus.bfly_valid), 0);
    chk("rst_addr", {bus.addr_a, bus.addr_b, bus.tw_idx, bus.stage}, 0);
    rst_n = 1'b1;
    tick();

    // 1: asynchronous reset in the middle of ISSUE
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("mid_valid", 32'(bus.bfly_valid), 1);
    chk("mid_a", 32'(bus.addr_a), 8);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_done", 32'(bus.done), 0);
    chk("arst_valid", 32'(bus.bfly_valid), 0);
    chk("arst_fields", {bus.addr_a, bus.addr_b, bus.tw_idx, bus.stage}, 0);
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("post_rst_valid", 32'(bus.bfly_valid), 0);
    chk("post_rst_busy", 32'(bus.busy), 0);

    // 2: full run, ready held high
    run(0, -1);
    check_seq("full", 1'b1);
    chk("full_done_cyc", done_cyc, 45);
    chk("s0b3", {oa[3][7:0], ob[3][7:0], ot[3][7:0]}, {8'd6, 8'd7, 8'd0});
    chk("s1b1", {oa[9][7:0], ob[9][7:0], ot[9][7:0]}, {8'd1, 8'd3, 8'd4});
    chk("s2b6", {oa[22][7:0], ob[22][7:0], ot[22][7:0]}, {8'd10, 8'd14, 8'd4});
    chk("s3b5", {oa[29][7:0], ob[29][7:0], ot[29][7:0]}, {8'd5, 8'd13, 8'd5});
    chk("done_busy", 32'(bus.busy), 0);
    tick();
    chk("done_pulse_1cyc", 32'(bus.done), 0);
    tick();

    // 3: five-cycle stall at s1 b2
    run(1, -1);
    check_seq("stall", 1'b0);
    chk("stall_done_cyc", done_cyc, 50);
    tick();
    tick();

    // 4: start while busy and during DONE is ignored, then restart after DONE
    run(0, 20);
    check_seq("poke", 1'b1);
    chk("poke_done_cyc", done_cyc, 45);
    bus.start = 1'b1;
    tick();
    chk("ignored_busy", 32'(bus.busy), 0);
    chk("ignored_valid", 32'(bus.bfly_valid), 0);
    chk("ignored_done", 32'(bus.done), 0);
    run(0, -1);
    check_seq("rerun", 1'b1);
    chk("rerun_done_cyc", done_cyc, 45);
    tick();
    tick();

    // 5: random ready
    run(2, -1);
    check_seq("rand", 1'b0);
    chk("rand_done_cyc", done_cyc, 45 + nstall);
    tick();

    // 6: 4-point FFT, PIPE_LAT=0
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    cyc2 = 1;
    n2 = 0;
    d2 = -1;
    while (cyc2 < 40 && d2 < 0) begin
      if (bus2.bfly_valid && n2 < 8) begin
        a2[n2] = int'(bus2.addr_a);
        b2[n2] = int'(bus2.addr_b);
        t2[n2] = int'(bus2.tw_idx);
        n2++;
      end
      if (bus2.done) begin
        d2 = cyc2;
      end else begin
        tick();
        cyc2++;
      end
    end
    chk("n4_count", n2, 4);
    if (n2 >= 4) begin
      chk("n4_bf0", {a2[0][3:0], b2[0][3:0], t2[0][3:0]}, {4'd0, 4'd1, 4'd0});
      chk("n4_bf1", {a2[1][3:0], b2[1][3:0], t2[1][3:0]}, {4'd2, 4'd3, 4'd0});
      chk("n4_bf2", {a2[2][3:0], b2[2][3:0], t2[2][3:0]}, {4'd0, 4'd2, 4'd0});
      chk("n4_bf3", {a2[3][3:0], b2[3][3:0], t2[3][3:0]}, {4'd1, 4'd3, 4'd1});
    end
    chk("n4_done_cyc", d2, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
